fixed_point_mac_accumulator: RTL and testbench

- Sequential accumulation stage directly downstream of Fixed_Point_Multiplier.
- Consumes a stream of Q16.16 products (p_out) and their overflow flags, and sums a programmed number of them in a widened internal accumulator.
- Returns one saturated Q16.16 sum with a sticky overflow flag over a valid/ready handshake.
- Forms the sum-of-products core (Σxy, Σx², Σx) of the linear regressor datapath.

---
 rtl/fixed_point_mac_accumulator_if.sv | 26 ++
 rtl/fixed_point_mac_accumulator.sv | 130 +++++++++++++
 tb/tb_fixed_point_mac_accumulator.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fixed_point_mac_accumulator_if.sv
// Product-in / sum-out handshake bundle between the multiplier stream, the
// accumulator and its consumer.
interface fixed_point_mac_accumulator_if #(
    parameter int DATA_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] prod_in;
    logic              prod_ovf;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] sum_out;
    logic              sum_ovf;

    // master: upstream producer plus downstream consumer of the sum
    modport master (
        output in_valid, prod_in, prod_ovf, out_ready,
        input  in_ready, out_valid, sum_out, sum_ovf
    );

    // slave: the accumulator itself
    modport slave (
        input  in_valid, prod_in, prod_ovf, out_ready,
        output in_ready, out_valid, sum_out, sum_ovf
    );
endinterface

// File: rtl/fixed_point_mac_accumulator.sv
// Sums a programmed number of signed Q16.16 products in a widened accumulator
// and returns one saturated Q16.16 sum with a sticky overflow flag.
module fixed_point_mac_accumulator #(
    parameter int DATA_W     = 32,
    parameter int FRACT_BITS = 16,
    parameter int ACC_W      = 48,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [CNT_W-1:0]              num_samples,
    output logic                          busy,
    fixed_point_mac_accumulator_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [CNT_W-1:0]        CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // The accumulator must be wide enough that no legal frame can wrap it.
    generate
        if (ACC_W < DATA_W + CNT_W || FRACT_BITS >= DATA_W) begin : g_bad_params
            $error("fixed_point_mac_accumulator: illegal ACC_W/CNT_W/FRACT_BITS combination");
        end
    endgenerate

    logic [1:0]               state_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic [CNT_W-1:0]         len_reg;
    logic                     ovf_sticky_reg;
    logic [DATA_W-1:0]        sum_out_reg;
    logic                     sum_ovf_reg;
    logic                     out_valid_reg;

    logic                     in_ready_int;
    logic                     beat;
    logic                     last_beat;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_final;
    logic                     sat_hi;
    logic                     sat_lo;
    logic [DATA_W-1:0]        sat_val;

    assign in_ready_int = (state_reg == ACCUM);
    assign busy         = (state_reg != IDLE);

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum_out   = sum_out_reg;
    assign bus.sum_ovf   = sum_ovf_reg;

    assign beat      = bus.in_valid & in_ready_int;
    assign last_beat = beat & (cnt_reg == len_reg - CNT_ONE);
    assign prod_ext  = {{(ACC_W-DATA_W){bus.prod_in[DATA_W-1]}}, bus.prod_in};
    assign acc_final = acc_reg + prod_ext;

    // Clamp only on the final sum; exact range limits pass through unflagged.
    always_comb begin
        sat_hi  = (acc_final > SAT_MAX);
        sat_lo  = (acc_final < SAT_MIN);
        sat_val = acc_final[DATA_W-1:0];
        if (sat_hi) begin
            sat_val = SAT_MAX[DATA_W-1:0];
        end else if (sat_lo) begin
            sat_val = SAT_MIN[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            len_reg        <= '0;
            ovf_sticky_reg <= 1'b0;
            sum_out_reg    <= '0;
            sum_ovf_reg    <= 1'b0;
            out_valid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (num_samples != '0) begin
                            len_reg        <= num_samples;
                            acc_reg        <= '0;
                            cnt_reg        <= '0;
                            ovf_sticky_reg <= 1'b0;
                            state_reg      <= ACCUM;
                        end else begin
                            sum_out_reg   <= '0;
                            sum_ovf_reg   <= 1'b0;
                            out_valid_reg <= 1'b1;
                            state_reg     <= HOLD;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc_reg        <= acc_final;
                        cnt_reg        <= cnt_reg + CNT_ONE;
                        ovf_sticky_reg <= ovf_sticky_reg | bus.prod_ovf;
                        if (last_beat) begin
                            sum_out_reg   <= sat_val;
                            sum_ovf_reg   <= ovf_sticky_reg | bus.prod_ovf | sat_hi | sat_lo;
                            out_valid_reg <= 1'b1;
                            state_reg     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_mac_accumulator.sv
// Randomized and directed frames checked against a plain-arithmetic sum model.
module tb_fixed_point_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_samples = '0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] fd [16];
    bit          fo [16];

    fixed_point_mac_accumulator_if #(.DATA_W(32)) bus ();

    fixed_point_mac_accumulator #(
        .DATA_W(32), .FRACT_BITS(16), .ACC_W(48), .CNT_W(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_samples (num_samples),
        .busy        (busy),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer sum of the frame, then clamp to the Q16.16 range.
    function automatic logic [32:0] model(input int len);
        longint s  = 0;
        bit     ov = 1'b0;
        logic [31:0] r;
        for (int i = 0; i < len; i++) begin
            s  += longint'($signed(fd[i]));
            ov |= fo[i];
        end
        if (s > 64'sd2147483647) begin
            r  = 32'h7FFF_FFFF;
            ov = 1'b1;
        end else if (s < -64'sd2147483648) begin
            r  = 32'h8000_0000;
            ov = 1'b1;
        end else begin
            r = s[31:0];
        end
        return {ov, r};
    endfunction

    task automatic send_beat(input logic [31:0] d, input bit o);
        int waitc = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.prod_in  = d;
        bus.prod_ovf = o;
        while (!bus.in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 100) check("in_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.prod_ovf = 1'b0;
    endtask

    task automatic start_frame(input int len);
        @(negedge clk);
        start       = 1'b1;
        num_samples = 16'(len);
        @(posedge clk);
        #1;
        start       = 1'b0;
        num_samples = 16'($urandom);
    endtask

    task automatic run_frame(input string name, input int len, input int gap, input int hold);
        logic [32:0] exp;
        exp = model(len);
        start_frame(len);
        for (int i = 0; i < len; i++) begin
            repeat (gap) @(negedge clk);
            send_beat(fd[i], fo[i]);
        end
        // One cycle after the last handshake (or the zero-length start).
        @(negedge clk);
        check({name, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        check({name, "_sum_out"},   64'(bus.sum_out),   64'(exp[31:0]));
        check({name, "_sum_ovf"},   64'(bus.sum_ovf),   64'(exp[32]));
        check({name, "_in_ready"},  64'(bus.in_ready),  64'd0);
        $display("frame %s len=%0d sum_out=%h sum_ovf=%b expected %h/%b",
                 name, len, bus.sum_out, bus.sum_ovf, exp[31:0], exp[32]);
        for (int h = 0; h < hold; h++) begin
            start        = h[0];
            num_samples  = 16'd5;
            bus.in_valid = 1'b1;
            @(negedge clk);
            check({name, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            check({name, "_hold_sum"},   64'({bus.sum_ovf, bus.sum_out}), 64'(exp));
            check({name, "_hold_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        start         = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        start         = 1'b0;
        @(negedge clk);
        check({name, "_done_valid"}, 64'(bus.out_valid), 64'd0);
        check({name, "_done_busy"},  64'(busy), 64'd0);
        check({name, "_done_keep"},  64'(bus.sum_out), 64'(exp[31:0]));
    endtask

    task automatic fill(input int i, input logic [31:0] d, input bit o);
        fd[i] = d;
        fo[i] = o;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.prod_in   = '0;
        bus.prod_ovf  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 64'({busy, bus.in_ready, bus.out_valid, bus.sum_ovf, bus.sum_out}), 64'd0);
        rst_n = 1'b1;

        // A beat offered in IDLE must not be taken.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.prod_in  = 32'h1234_5678;
        @(negedge clk);
        check("idle_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b0;

        fill(0, 32'h0001_0000, 0); fill(1, 32'h0002_8000, 0);
        fill(2, 32'hFFFF_8000, 0); fill(3, 32'h0000_4000, 0);
        run_frame("mixed4", 4, 0, 0);
        check("mixed4_const", 64'(bus.sum_out), 64'h0003_4000);

        for (int i = 0; i < 3; i++) fill(i, 32'h7FFF_0000, 0);
        run_frame("satpos", 3, 0, 1);
        check("satpos_const", 64'({bus.sum_ovf, bus.sum_out}), 64'h1_7FFF_FFFF);

        for (int i = 0; i < 2; i++) fill(i, 32'h8000_0000, 0);
        run_frame("satneg", 2, 0, 0);
        check("satneg_const", 64'({bus.sum_ovf, bus.sum_out}), 64'h1_8000_0000);

        fill(0, 32'h7FFF_0000, 0); fill(1, 32'h8001_0000, 0);
        run_frame("cancel", 2, 0, 0);
        check("cancel_const", 64'({bus.sum_ovf, bus.sum_out}), 64'h0_0000_0000);

        for (int i = 0; i < 3; i++) fill(i, 32'h0001_0000, i == 1);
        run_frame("gaps", 3, 2, 5);
        check("gaps_const", 64'({bus.sum_ovf, bus.sum_out}), 64'h1_0003_0000);

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 4; i++) fill(i, 32'h0005_0000, 1);
        start_frame(4);
        send_beat(fd[0], fo[0]);
        send_beat(fd[1], fo[1]);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 64'({busy, bus.in_ready, bus.out_valid, bus.sum_ovf, bus.sum_out}), 64'd0);
        $display("reset mid-frame busy=%b sum_out=%h", busy, bus.sum_out);
        @(negedge clk);
        rst_n = 1'b1;

        fill(0, 32'h0002_0000, 0);
        run_frame("after_rst", 1, 0, 0);
        check("after_rst_const", 64'(bus.sum_out), 64'h0002_0000);

        run_frame("zero_len", 0, 0, 2);

        for (int f = 0; f < 12; f++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                logic [31:0] v;
                case ($urandom_range(0, 3))
                    0: v = $urandom;
                    1: begin
                        v = $urandom & 32'h0003_FFFF;
                        if ($urandom_range(0, 1) == 1) v = -v;
                    end
                    2: v = 32'h7FF0_0000 | ($urandom & 32'h000F_FFFF);
                    default: v = 32'h8000_0000 | ($urandom & 32'h000F_FFFF);
                endcase
                fill(i, v, $urandom_range(0, 7) == 0);
            end
            run_frame($sformatf("rand%0d", f), len, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
